wbu2idu_sb: RTL and testbench

- Writeback-to-decode feedback scoreboard. It closes the loop that the IDU-to-EXU stage register opens.
- Tracks destination registers of instructions issued past IDU and not yet written back by WBU.
- Stalls IDU on RAW/WAW hazards and bypasses same-cycle writeback data to IDU operands.
- Sits beside IDU: issue side observes the IDU-to-EXU handshake; writeback side consumes the WBU register-write channel.

---
 rtl/wbu2idu_sb_pkg.sv | 18 +
 rtl/wbu2idu_sb_if.sv | 45 ++++
 rtl/wbu2idu_sb_hzd_chk.sv | 23 ++
 rtl/wbu2idu_sb.sv | 87 ++++++++
 tb/tb_wbu2idu_sb.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbu2idu_sb_pkg.sv
// Shared widths, types and constants for the writeback-to-decode scoreboard.
package wbu2idu_sb_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 2;
  localparam int PEND_W     = 7;

  typedef logic [REG_ADDR_W-1:0] reg_id_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [PEND_W-1:0]     pend_t;
  typedef logic [DATA_W-1:0]     data_t;

  localparam reg_id_t REG_X0  = '0;
  localparam cnt_t    CNT_MAX = '1;

endpackage

// File: rtl/wbu2idu_sb_if.sv
// IDU issue-side and WBU writeback-side signals seen by the scoreboard.
interface wbu2idu_sb_if;
  import wbu2idu_sb_pkg::*;

  logic    i_idu_valid;
  logic    i_i2e_ready;
  logic    i_idu_rs1_en;
  logic    i_idu_rs2_en;
  reg_id_t i_idu_rs1_id;
  reg_id_t i_idu_rs2_id;
  logic    i_idu_reg_wr_en;
  reg_id_t i_idu_rd_id;
  logic    o_sb_stall;
  logic    o_sb_rs1_byp_en;
  logic    o_sb_rs2_byp_en;
  data_t   o_sb_rs1_byp_data;
  data_t   o_sb_rs2_byp_data;
  logic    i_wbu_valid;
  logic    o_sb_wbu_ready;
  logic    i_wbu_reg_wr_en;
  reg_id_t i_wbu_rd_id;
  data_t   i_wbu_data;
  pend_t   o_sb_pend_cnt;
  logic    o_sb_idle;
  logic    o_sb_err;

  modport master (
    output i_idu_valid, i_i2e_ready, i_idu_rs1_en, i_idu_rs2_en,
           i_idu_rs1_id, i_idu_rs2_id, i_idu_reg_wr_en, i_idu_rd_id,
           i_wbu_valid, i_wbu_reg_wr_en, i_wbu_rd_id, i_wbu_data,
    input  o_sb_stall, o_sb_rs1_byp_en, o_sb_rs2_byp_en,
           o_sb_rs1_byp_data, o_sb_rs2_byp_data, o_sb_wbu_ready,
           o_sb_pend_cnt, o_sb_idle, o_sb_err
  );

  modport slave (
    input  i_idu_valid, i_i2e_ready, i_idu_rs1_en, i_idu_rs2_en,
           i_idu_rs1_id, i_idu_rs2_id, i_idu_reg_wr_en, i_idu_rd_id,
           i_wbu_valid, i_wbu_reg_wr_en, i_wbu_rd_id, i_wbu_data,
    output o_sb_stall, o_sb_rs1_byp_en, o_sb_rs2_byp_en,
           o_sb_rs1_byp_data, o_sb_rs2_byp_data, o_sb_wbu_ready,
           o_sb_pend_cnt, o_sb_idle, o_sb_err
  );

endinterface

// File: rtl/wbu2idu_sb_hzd_chk.sv
// Per-source RAW check: stall while any write to the source is pending,
// unless the only pending write is being written back this very cycle.
module wbu2idu_sb_hzd_chk
  import wbu2idu_sb_pkg::*;
(
  input  logic    rs_en_i,
  input  reg_id_t rs_id_i,
  input  cnt_t    rs_cnt_i,
  input  logic    wb_fire_i,
  input  reg_id_t wb_rd_id_i,
  output logic    raw_stall_o,
  output logic    byp_en_o
);

  logic pending;
  logic wb_hit;

  assign pending     = rs_en_i & (rs_id_i != REG_X0) & (rs_cnt_i != '0);
  assign wb_hit      = wb_fire_i & (wb_rd_id_i == rs_id_i);
  assign byp_en_o    = pending & wb_hit & (rs_cnt_i == cnt_t'(1));
  assign raw_stall_o = pending & ~byp_en_o;

endmodule

// File: rtl/wbu2idu_sb.sv
// Writeback-to-decode scoreboard: per-GPR in-flight write counters that stall
// IDU on RAW/WAW hazards and forward same-cycle writeback data.
module wbu2idu_sb
  import wbu2idu_sb_pkg::*;
(
  input  logic         i_sys_clk,
  input  logic         i_sys_rst,
  wbu2idu_sb_if.slave  sb_if
);

  cnt_t  cnt_q [REG_NUM];
  cnt_t  cnt_d [REG_NUM];
  pend_t pend_q, pend_d;
  logic  err_q, err_d;

  logic wb_fire, wb_underflow, wb_dec;
  logic iss_fire, waw_stall, raw1_stall, raw2_stall, stall;

  assign wb_fire      = sb_if.i_wbu_valid & sb_if.i_wbu_reg_wr_en &
                        (sb_if.i_wbu_rd_id != REG_X0);
  assign wb_underflow = wb_fire & (cnt_q[sb_if.i_wbu_rd_id] == '0);
  assign wb_dec       = wb_fire & ~wb_underflow;

  wbu2idu_sb_hzd_chk u_rs1_chk (
    .rs_en_i     (sb_if.i_idu_rs1_en),
    .rs_id_i     (sb_if.i_idu_rs1_id),
    .rs_cnt_i    (cnt_q[sb_if.i_idu_rs1_id]),
    .wb_fire_i   (wb_fire),
    .wb_rd_id_i  (sb_if.i_wbu_rd_id),
    .raw_stall_o (raw1_stall),
    .byp_en_o    (sb_if.o_sb_rs1_byp_en)
  );

  wbu2idu_sb_hzd_chk u_rs2_chk (
    .rs_en_i     (sb_if.i_idu_rs2_en),
    .rs_id_i     (sb_if.i_idu_rs2_id),
    .rs_cnt_i    (cnt_q[sb_if.i_idu_rs2_id]),
    .wb_fire_i   (wb_fire),
    .wb_rd_id_i  (sb_if.i_wbu_rd_id),
    .raw_stall_o (raw2_stall),
    .byp_en_o    (sb_if.o_sb_rs2_byp_en)
  );

  // A saturated rd may still issue if one of its writes retires this cycle.
  assign waw_stall = sb_if.i_idu_reg_wr_en & (sb_if.i_idu_rd_id != REG_X0) &
                     (cnt_q[sb_if.i_idu_rd_id] == CNT_MAX) &
                     ~(wb_fire & (sb_if.i_wbu_rd_id == sb_if.i_idu_rd_id));
  assign stall     = sb_if.i_idu_valid & (raw1_stall | raw2_stall | waw_stall);
  assign iss_fire  = sb_if.i_idu_valid & sb_if.i_i2e_ready & ~stall &
                     sb_if.i_idu_reg_wr_en & (sb_if.i_idu_rd_id != REG_X0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      cnt_d[r] = cnt_q[r];
      if (iss_fire && (sb_if.i_idu_rd_id == reg_id_t'(r)))
        cnt_d[r] = cnt_d[r] + cnt_t'(1);
      if (wb_dec && (sb_if.i_wbu_rd_id == reg_id_t'(r)))
        cnt_d[r] = cnt_d[r] - cnt_t'(1);
    end
    pend_d = pend_q + pend_t'(iss_fire) - pend_t'(wb_dec);
    err_d  = err_q | wb_underflow;
  end

  // NOTE: the counter array is architectural tracking state, so unlike a
  // data RAM it must be cleared on reset; state uses non-blocking assignments.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign sb_if.o_sb_stall        = stall;
  assign sb_if.o_sb_rs1_byp_data = sb_if.i_wbu_data;
  assign sb_if.o_sb_rs2_byp_data = sb_if.i_wbu_data;
  assign sb_if.o_sb_wbu_ready    = 1'b1;
  assign sb_if.o_sb_pend_cnt     = pend_q;
  assign sb_if.o_sb_idle         = (pend_q == '0);
  assign sb_if.o_sb_err          = err_q;

endmodule

// File: tb/tb_wbu2idu_sb.sv
// Self-checking bench for wbu2idu_sb: directed hazard scenarios followed by
// random traffic compared against a per-register pending-write model.
module tb_wbu2idu_sb;
  import wbu2idu_sb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wbu2idu_sb_if sb_if ();

  wbu2idu_sb dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .sb_if     (sb_if)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: number of not-yet-written-back writes per register.
  int  pending [REG_NUM];
  int  total_pending;
  bit  err_m;
  bit  exp_stall, exp_byp1, exp_byp2;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (pending[r]) pending[r] = 0;
    total_pending = 0;
    err_m = 1'b0;
  endtask

  task automatic set_idu(bit v, bit rdy, bit e1, int s1, bit e2, int s2, bit wr, int rd);
    sb_if.i_idu_valid     = v;
    sb_if.i_i2e_ready     = rdy;
    sb_if.i_idu_rs1_en    = e1;
    sb_if.i_idu_rs1_id    = reg_id_t'(s1);
    sb_if.i_idu_rs2_en    = e2;
    sb_if.i_idu_rs2_id    = reg_id_t'(s2);
    sb_if.i_idu_reg_wr_en = wr;
    sb_if.i_idu_rd_id     = reg_id_t'(rd);
  endtask

  task automatic set_wbu(bit v, bit wr, int rd, logic [31:0] data);
    sb_if.i_wbu_valid     = v;
    sb_if.i_wbu_reg_wr_en = wr;
    sb_if.i_wbu_rd_id     = reg_id_t'(rd);
    sb_if.i_wbu_data      = data;
  endtask

  task automatic set_quiet();
    set_idu(0, 0, 0, 0, 0, 0, 0, 0);
    set_wbu(0, 0, 0, 32'h0);
  endtask

  function automatic bit wb_writes(int r);
    return sb_if.i_wbu_valid && sb_if.i_wbu_reg_wr_en &&
           int'(sb_if.i_wbu_rd_id) == r && r != 0;
  endfunction

  // A source must wait while writes are pending, unless the last one lands now.
  function automatic bit src_resolves(bit en, int id);
    return en && id != 0 && pending[id] == 1 && wb_writes(id);
  endfunction

  function automatic bit src_blocks(bit en, int id);
    return en && id != 0 && pending[id] > 0 && !src_resolves(en, id);
  endfunction

  // Settle after inputs change and compare every output with the model.
  task automatic settle();
    int s1, s2, rd;
    bit waw;
    #1;
    s1 = int'(sb_if.i_idu_rs1_id);
    s2 = int'(sb_if.i_idu_rs2_id);
    rd = int'(sb_if.i_idu_rd_id);
    waw = sb_if.i_idu_reg_wr_en && rd != 0 && pending[rd] == 3 && !wb_writes(rd);
    exp_byp1  = src_resolves(sb_if.i_idu_rs1_en, s1);
    exp_byp2  = src_resolves(sb_if.i_idu_rs2_en, s2);
    exp_stall = sb_if.i_idu_valid &&
                (src_blocks(sb_if.i_idu_rs1_en, s1) ||
                 src_blocks(sb_if.i_idu_rs2_en, s2) || waw);
    check("stall", 32'(sb_if.o_sb_stall), 32'(exp_stall));
    check("rs1_byp_en", 32'(sb_if.o_sb_rs1_byp_en), 32'(exp_byp1));
    check("rs2_byp_en", 32'(sb_if.o_sb_rs2_byp_en), 32'(exp_byp2));
    if (exp_byp1) check("rs1_byp_data", sb_if.o_sb_rs1_byp_data, sb_if.i_wbu_data);
    if (exp_byp2) check("rs2_byp_data", sb_if.o_sb_rs2_byp_data, sb_if.i_wbu_data);
    check("pend_cnt", 32'(sb_if.o_sb_pend_cnt), 32'(total_pending));
    check("idle", 32'(sb_if.o_sb_idle), 32'(total_pending == 0));
    check("err", 32'(sb_if.o_sb_err), 32'(err_m));
    check("wbu_ready", 32'(sb_if.o_sb_wbu_ready), 32'd1);
  endtask

  // Clock edge: apply retire/issue to the model, then return to the falling edge.
  task automatic tick();
    int rd, wr;
    bit issue;
    rd    = int'(sb_if.i_idu_rd_id);
    wr    = int'(sb_if.i_wbu_rd_id);
    issue = sb_if.i_idu_valid && sb_if.i_i2e_ready && !exp_stall &&
            sb_if.i_idu_reg_wr_en && rd != 0;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (wb_writes(wr)) begin
        if (pending[wr] == 0) err_m = 1'b1;
        else begin
          pending[wr]--;
          total_pending--;
        end
      end
      if (issue) begin
        pending[rd]++;
        total_pending++;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue_rd(int rd);
    set_quiet();
    set_idu(1, 1, 0, 0, 0, 0, 1, rd);
    settle();
    tick();
  endtask

  task automatic retire_rd(int rd, logic [31:0] data);
    set_quiet();
    set_wbu(1, 1, rd, data);
    settle();
    tick();
  endtask

  initial begin
    model_clear();
    exp_stall = 1'b0;
    set_quiet();

    // Reset for two cycles with a busy-looking IDU.
    rst = 1'b1;
    set_idu(1, 1, 1, 5, 1, 7, 1, 3);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_idu(1, 0, 1, 5, 1, 7, 1, 3);
    settle();
    check("reset_stall", 32'(sb_if.o_sb_stall), 32'd0);
    check("reset_idle", 32'(sb_if.o_sb_idle), 32'd1);
    check("reset_pend", 32'(sb_if.o_sb_pend_cnt), 32'd0);
    check("reset_err", 32'(sb_if.o_sb_err), 32'd0);
    tick();

    // RAW stall then same-cycle bypass release.
    issue_rd(5);
    set_quiet();
    set_idu(1, 1, 1, 5, 0, 0, 0, 0);
    settle();
    check("raw_stall", 32'(sb_if.o_sb_stall), 32'd1);
    tick();
    set_wbu(1, 1, 5, 32'hDEADBEEF);
    settle();
    check("raw_release", 32'(sb_if.o_sb_stall), 32'd0);
    check("raw_byp_en", 32'(sb_if.o_sb_rs1_byp_en), 32'd1);
    check("raw_byp_data", sb_if.o_sb_rs1_byp_data, 32'hDEADBEEF);
    tick();
    set_quiet();
    settle();
    check("raw_pend0", 32'(sb_if.o_sb_pend_cnt), 32'd0);
    tick();

    // Two writes pending to x7: the first writeback must not release rs2.
    issue_rd(7);
    issue_rd(7);
    set_quiet();
    set_idu(1, 1, 0, 0, 1, 7, 0, 0);
    set_wbu(1, 1, 7, 32'h1111_0007);
    settle();
    check("dbl_stall", 32'(sb_if.o_sb_stall), 32'd1);
    tick();
    set_wbu(1, 1, 7, 32'h2222_0007);
    settle();
    check("dbl_release", 32'(sb_if.o_sb_stall), 32'd0);
    check("dbl_byp2", 32'(sb_if.o_sb_rs2_byp_en), 32'd1);
    tick();
    set_quiet();
    settle();
    check("dbl_pend0", 32'(sb_if.o_sb_pend_cnt), 32'd0);
    tick();

    // WAW saturation on x3.
    issue_rd(3);
    issue_rd(3);
    issue_rd(3);
    set_quiet();
    set_idu(1, 1, 0, 0, 0, 0, 1, 3);
    settle();
    check("waw_stall", 32'(sb_if.o_sb_stall), 32'd1);
    check("waw_pend3", 32'(sb_if.o_sb_pend_cnt), 32'd3);
    tick();
    set_wbu(1, 1, 3, 32'h3);
    settle();
    check("waw_release", 32'(sb_if.o_sb_stall), 32'd0);
    tick();
    set_wbu(0, 0, 0, 32'h0);
    settle();
    check("waw_still_sat", 32'(sb_if.o_sb_stall), 32'd1);
    check("waw_pend_hold", 32'(sb_if.o_sb_pend_cnt), 32'd3);
    tick();
    for (int i = 0; i < 3; i++) retire_rd(3, 32'(i));

    // Issue and writeback to x9 in the same cycle keep its count at 1.
    issue_rd(9);
    set_quiet();
    set_idu(1, 1, 0, 0, 0, 0, 1, 9);
    set_wbu(1, 1, 9, 32'h9);
    settle();
    check("sim_no_stall", 32'(sb_if.o_sb_stall), 32'd0);
    tick();
    set_quiet();
    set_idu(1, 1, 1, 9, 0, 0, 0, 0);
    settle();
    check("sim_pend1", 32'(sb_if.o_sb_pend_cnt), 32'd1);
    check("sim_cnt1_stall", 32'(sb_if.o_sb_stall), 32'd1);
    tick();
    retire_rd(9, 32'h99);

    // x0 handling, then underflow on x12.
    retire_rd(0, 32'hFFFF_FFFF);
    set_quiet();
    settle();
    check("x0_wb_no_err", 32'(sb_if.o_sb_err), 32'd0);
    tick();
    issue_rd(0);
    set_quiet();
    set_idu(1, 1, 1, 0, 1, 0, 0, 0);
    settle();
    check("x0_pend", 32'(sb_if.o_sb_pend_cnt), 32'd0);
    check("x0_no_stall", 32'(sb_if.o_sb_stall), 32'd0);
    tick();
    retire_rd(12, 32'hC);
    set_quiet();
    settle();
    check("uf_err", 32'(sb_if.o_sb_err), 32'd1);
    check("uf_pend", 32'(sb_if.o_sb_pend_cnt), 32'd0);
    tick();
    set_quiet();
    settle();
    check("uf_err_sticky", 32'(sb_if.o_sb_err), 32'd1);
    tick();

    // Reset while writes are pending discards all tracking.
    issue_rd(4);
    issue_rd(6);
    rst = 1'b1;
    set_quiet();
    tick();
    rst = 1'b0;
    set_idu(1, 1, 1, 4, 1, 6, 0, 0);
    settle();
    check("mid_rst_pend", 32'(sb_if.o_sb_pend_cnt), 32'd0);
    check("mid_rst_err", 32'(sb_if.o_sb_err), 32'd0);
    check("mid_rst_stall", 32'(sb_if.o_sb_stall), 32'd0);
    tick();

    // Random traffic on a small register window; writebacks only retire
    // registers that have pending writes, or target x0 / carry no write.
    for (int cyc = 0; cyc < 600; cyc++) begin
      int live [$];
      set_idu($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 75,
              $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 99) < 70, $urandom_range(0, 7));
      for (int r = 1; r < REG_NUM; r++) if (pending[r] > 0) live.push_back(r);
      if (live.size() > 0 && $urandom_range(0, 99) < 45)
        set_wbu(1, 1, live[$urandom_range(0, live.size() - 1)], $urandom);
      else
        case ($urandom_range(0, 2))
          0:       set_wbu(1, 1, 0, $urandom);
          1:       set_wbu(1, 0, $urandom_range(1, 31), $urandom);
          default: set_wbu(0, 1, $urandom_range(1, 31), $urandom);
        endcase
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
